// File: rtl/sc_chain_loader.sv
// Serial scan-chain loader: shifts words LSB-first into a CHAIN_LEN-stage chain.
// Define SC_CHAIN_LOADER_READBACK_EN to capture sc_tail into rb_data per word group.
module sc_chain_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int CHAIN_LEN  = 20,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din_data,
  output logic                  din_ready,
  output logic                  sc_head,
  output logic                  sc_shift_en,
  input  logic                  sc_tail,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  rb_valid
);

  localparam int WB = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic [CNT_WIDTH-1:0]  remaining, remaining_nx;
  logic [WB-1:0]         word_bits, word_bits_nx;
  logic                  grp_end;

  always_comb begin
    state_nx     = state;
    shreg_nx     = shreg;
    remaining_nx = remaining;
    word_bits_nx = word_bits;
    grp_end      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx     = LOAD;
          remaining_nx = CNT_WIDTH'(CHAIN_LEN);
        end
      end
      LOAD: begin
        if (din_valid) begin
          shreg_nx     = din_data;
          word_bits_nx = (remaining < CNT_WIDTH'(DATA_WIDTH)) ?
                         WB'(remaining) : WB'(DATA_WIDTH);
          state_nx     = SHIFT;
        end
      end
      SHIFT: begin
        shreg_nx     = shreg >> 1;
        word_bits_nx = word_bits - WB'(1);
        remaining_nx = remaining - CNT_WIDTH'(1);
        if (word_bits == WB'(1)) begin
          grp_end  = 1'b1;
          state_nx = (remaining == CNT_WIDTH'(1)) ? DONE : LOAD;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      grp_end  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      remaining <= '0;
      word_bits <= '0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      remaining <= remaining_nx;
      word_bits <= word_bits_nx;
    end
  end

  assign din_ready   = (state == LOAD);
  assign sc_shift_en = (state == SHIFT);
  assign sc_head     = (state == SHIFT) & shreg[0];
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

`ifdef SC_CHAIN_LOADER_READBACK_EN
  // rb_bit marks where the next tail bit lands, so partial groups stay right-aligned
  logic [DATA_WIDTH-1:0] rb_acc, rb_bit, rb_q, rb_cur;
  logic                  rb_v;

  assign rb_cur = rb_acc | (sc_tail ? rb_bit : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rb_acc <= '0;
      rb_bit <= '0;
      rb_q   <= '0;
      rb_v   <= 1'b0;
    end else begin
      rb_v <= 1'b0;
      if (state == LOAD) begin
        rb_acc <= '0;
        rb_bit <= DATA_WIDTH'(1);
      end else if (state == SHIFT && !abort) begin
        rb_acc <= rb_cur;
        rb_bit <= rb_bit << 1;
        if (grp_end) begin
          rb_q <= rb_cur;
          rb_v <= 1'b1;
        end
      end
    end
  end

  assign rb_data  = rb_q;
  assign rb_valid = rb_v;
`else
  logic unused_tail;
  assign unused_tail = sc_tail ^ grp_end;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_sc_chain_loader.sv
// Randomized bench for sc_chain_loader against a bit-stream/chain model.
// Drives a 20-stage instance with a chain model plus a 1-stage instance.
module tb_sc_chain_loader;
  localparam int L = 20;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset, start, abort, din_valid, sc_tail;
  logic [7:0] din_data;
  logic       din_ready, sc_head, sc_shift_en, busy, done, rb_valid;
  logic [7:0] rb_data;

  logic       s1_start, s1_abort, s1_valid, s1_tail;
  logic [7:0] s1_data;
  logic       s1_ready, s1_head, s1_shift, s1_busy, s1_done, s1_rbv;
  logic [7:0] s1_rb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sc_chain_loader #(.DATA_WIDTH(W), .CHAIN_LEN(L), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .din_valid(din_valid), .din_data(din_data), .din_ready(din_ready),
    .sc_head(sc_head), .sc_shift_en(sc_shift_en), .sc_tail(sc_tail),
    .busy(busy), .done(done), .rb_data(rb_data), .rb_valid(rb_valid)
  );

  sc_chain_loader #(.DATA_WIDTH(W), .CHAIN_LEN(1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .start(s1_start), .abort(s1_abort),
    .din_valid(s1_valid), .din_data(s1_data), .din_ready(s1_ready),
    .sc_head(s1_head), .sc_shift_en(s1_shift), .sc_tail(s1_tail),
    .busy(s1_busy), .done(s1_done), .rb_data(s1_rb), .rb_valid(s1_rbv)
  );

  // chain of sc_dff stages: stage 0 fed by sc_head, tail is stage L-1
  logic [L-1:0] chain = '0;
  logic [L-1:0] preload_val;
  logic         preload_req = 1'b0;
  assign sc_tail = chain[L-1];
  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (sc_shift_en) chain <= {chain[L-2:0], sc_head};
  end

  logic [L-1:0] hs;
  int nshift, ndone, done_at, stall_bad;
  logic [7:0] rbq[$];

  function automatic logic [L-1:0] exp_chain(input logic [23:0] w);
    logic [L-1:0] c;
    for (int k = 0; k < L; k++) c[L-1-k] = w[k];
    return c;
  endfunction

  function automatic logic [7:0] exp_rb(input logic [L-1:0] init, input int g);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < W; j++)
      if (g * W + j < L) r[j] = init[L-1-(g*W+j)];
    return r;
  endfunction

  function automatic int exp_lat();
    return L + (L + W - 1) / W + 1;
  endfunction

  task automatic run_load(input logic [23:0] words, input logic [L-1:0] init,
                          input int gap_pct, input int stall, input bit poke);
    int widx;
    widx = 0; nshift = 0; ndone = 0; done_at = 0; stall_bad = 0;
    hs = '0;
    rbq.delete();
    preload_val = init; preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
    start = 1'b1; din_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (sc_shift_en) begin
        if (nshift < L) hs[nshift] = sc_head;
        nshift++;
      end
      if (rb_valid) rbq.push_back(rb_data);
      if (done) begin
        ndone++;
        if (done_at == 0) done_at = cyc;
      end
      if (done_at != 0 && !busy) break;
      din_data = (widx < 3) ? words[widx*8 +: 8] : 8'h00;
      if (cyc <= stall) begin
        din_valid = 1'b0;
        if (din_ready !== 1'b1 || sc_shift_en !== 1'b0) stall_bad++;
      end else begin
        din_valid = ($urandom_range(99) >= gap_pct);
      end
      start = poke && busy;
      if (din_ready && din_valid) widx++;
      @(negedge clk);
    end
    din_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; din_valid = 1'b1; abort = 1'b0;
    s1_start = 1'b1; s1_valid = 1'b1; s1_abort = 1'b0;
    din_data = 8'hFF; s1_data = 8'hFF; s1_tail = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({din_ready, sc_head, sc_shift_en, busy, done, rb_valid, rb_data} !== 14'h0) begin
      bad++;
      $display("FAIL reset_outs got=%b want=0",
               {din_ready, sc_head, sc_shift_en, busy, done, rb_valid, rb_data});
    end
    total++;
    if ({s1_ready, s1_head, s1_shift, s1_busy, s1_done, s1_rbv, s1_rb} !== 14'h0) begin
      bad++;
      $display("FAIL reset_outs_l1 got=%b want=0",
               {s1_ready, s1_head, s1_shift, s1_busy, s1_done, s1_rbv, s1_rb});
    end
    reset = 1'b0; start = 1'b0; din_valid = 1'b0;
    s1_start = 1'b0; s1_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle busy=%b want=0", busy);
    end
  endtask

  task automatic check_load(input string nm, input logic [23:0] w,
                            input logic [L-1:0] init);
    total++;
    if (hs !== w[L-1:0]) begin
      bad++; $display("FAIL %s_head got=%h want=%h", nm, hs, w[L-1:0]);
    end
    total++;
    if (nshift != L) begin
      bad++; $display("FAIL %s_nshift got=%0d want=%0d", nm, nshift, L);
    end
    total++;
    if (ndone != 1) begin
      bad++; $display("FAIL %s_ndone got=%0d want=1", nm, ndone);
    end
    total++;
    if (chain !== exp_chain(w)) begin
      bad++; $display("FAIL %s_chain got=%h want=%h", nm, chain, exp_chain(w));
    end
`ifdef SC_CHAIN_LOADER_READBACK_EN
    total++;
    if (rbq.size() != 3) begin
      bad++; $display("FAIL %s_rb_count got=%0d want=3", nm, rbq.size());
    end else begin
      for (int g = 0; g < 3; g++) begin
        total++;
        if (rbq[g] !== exp_rb(init, g)) begin
          bad++;
          $display("FAIL %s_rb%0d got=%h want=%h", nm, g, rbq[g], exp_rb(init, g));
        end
      end
    end
`else
    total++;
    if (rbq.size() != 0) begin
      bad++; $display("FAIL %s_rb_count got=%0d want=0", nm, rbq.size());
    end
`endif
  endtask

  task automatic test_vector();
    run_load(24'h0F3CA5, 20'hFFFFF, 0, 0, 0);
    total++;
    if (hs !== 20'b1111_00111100_10100101) begin
      bad++; $display("FAIL vec_seq got=%b", hs);
    end
    total++;
    if (done_at != exp_lat()) begin
      bad++; $display("FAIL vec_done_at got=%0d want=%0d", done_at, exp_lat());
    end
    check_load("vec", 24'h0F3CA5, 20'hFFFFF);
  endtask

  task automatic test_random();
    logic [23:0] w;
    logic [L-1:0] init;
    for (int i = 0; i < 6; i++) begin
      w = 24'($urandom);
      init = L'($urandom);
      run_load(w, init, 40, 0, 0);
      check_load("rand", w, init);
    end
  endtask

  task automatic test_stall();
    logic [23:0] w;
    w = 24'($urandom);
    run_load(w, 20'h5A5A5, 0, 5, 0);
    total++;
    if (stall_bad != 0) begin
      bad++; $display("FAIL stall_hold got=%0d bad cycles want=0", stall_bad);
    end
    total++;
    if (done_at != exp_lat() + 5) begin
      bad++; $display("FAIL stall_done_at got=%0d want=%0d", done_at, exp_lat() + 5);
    end
    check_load("stall", w, 20'h5A5A5);
  endtask

  task automatic test_abort();
    int ns, extra;
    logic [23:0] w;
    ns = 0; extra = 0;
    din_data = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; din_valid = 1'b1;
    for (int c = 0; c < 100 && ns < 10; c++) begin
      if (sc_shift_en) ns++;
      if (ns == 10) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0; din_valid = 1'b0;
    total++;
    if (ns != 10 || busy !== 1'b0 || sc_shift_en !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle shifts=%0d busy=%b shift_en=%b want 10/0/0",
               ns, busy, sc_shift_en);
    end
    for (int c = 0; c < 5; c++) begin
      if (done || rb_valid || busy) extra++;
      @(negedge clk);
    end
    total++;
    if (extra != 0) begin
      bad++; $display("FAIL abort_quiet got=%0d active cycles want=0", extra);
    end
    w = 24'($urandom);
    run_load(w, 20'h0F0F0, 0, 0, 0);
    check_load("post_abort", w, 20'h0F0F0);
  endtask

  task automatic test_reset_mid();
    int ns;
    logic [L-1:0] snap;
    logic [23:0] w;
    ns = 0;
    din_data = 8'hC3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; din_valid = 1'b1;
    for (int c = 0; c < 100 && ns < 5; c++) begin
      if (sc_shift_en) ns++;
      if (ns == 5) begin
        reset = 1'b1; start = 1'b1;
      end
      @(negedge clk);
    end
    total++;
    if ({din_ready, sc_head, sc_shift_en, busy, done, rb_valid, rb_data} !== 14'h0) begin
      bad++;
      $display("FAIL rstmid_outs got=%b want=0",
               {din_ready, sc_head, sc_shift_en, busy, done, rb_valid, rb_data});
    end
    reset = 1'b0; start = 1'b0; din_valid = 1'b0;
    snap = chain;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || chain !== snap) begin
      bad++;
      $display("FAIL rstmid_hold busy=%b chain=%h want 0/%h", busy, chain, snap);
    end
    w = 24'($urandom);
    run_load(w, 20'h33333, 0, 0, 1);
    total++;
    if (done_at != exp_lat()) begin
      bad++; $display("FAIL poke_done_at got=%0d want=%0d", done_at, exp_lat());
    end
    check_load("poke", w, 20'h33333);
  endtask

  task automatic test_len1();
    logic [7:0] words[3];
    int ns, dat, nrb;
    logic hd;
    logic [7:0] rbv;
    words[0] = 8'hFE; words[1] = 8'h01; words[2] = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      ns = 0; dat = 0; nrb = 0; hd = 1'b0; rbv = '0;
      s1_tail = 1'($urandom);
      s1_data = words[i];
      s1_start = 1'b1;
      @(negedge clk);
      s1_start = 1'b0; s1_valid = 1'b1;
      for (int cyc = 1; cyc < 30; cyc++) begin
        if (s1_shift) begin ns++; hd = s1_head; end
        if (s1_done && dat == 0) dat = cyc;
        if (s1_rbv) begin nrb++; rbv = s1_rb; end
        @(negedge clk);
      end
      s1_valid = 1'b0;
      total++;
      if (ns != 1 || hd !== words[i][0]) begin
        bad++;
        $display("FAIL l1_shift n=%0d head=%b want 1/%b", ns, hd, words[i][0]);
      end
      total++;
      if (dat != 3) begin
        bad++; $display("FAIL l1_done_at got=%0d want=3", dat);
      end
`ifdef SC_CHAIN_LOADER_READBACK_EN
      total++;
      if (nrb != 1 || rbv !== {7'b0, s1_tail}) begin
        bad++;
        $display("FAIL l1_rb n=%0d got=%h want 1/%h", nrb, rbv, {7'b0, s1_tail});
      end
`else
      total++;
      if (nrb != 0 || s1_rb !== 8'h00) begin
        bad++; $display("FAIL l1_rb n=%0d data=%h want 0/00", nrb, s1_rb);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_random();
    test_stall();
    test_abort();
    test_reset_mid();
    test_len1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
